fragment_iterator: RTL

// - Scans a triangle's screen-space bounding box and emits one pixel coordinate per cycle, in raster order.
// - Sits directly downstream of bounding_box, after the FP->int conversion of its min/max outputs.
// - Feeds the barycentric-coordinate and fragment-clip stages; int->float conversion of sample points happens in the consumer.

---
 rtl/fragment_iterator_pkg.sv | 13 +
 rtl/fragment_iterator.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fragment_iterator_pkg.sv
// rtl/fragment_iterator_pkg.sv - shared defaults and state encoding for the fragment iterator
package fragment_iterator_pkg;

    localparam int DEF_COORD_W  = 10;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/fragment_iterator.sv
// rtl/fragment_iterator.sv - raster-order pixel walker over a clamped screen-space bounding box
module fragment_iterator
    import fragment_iterator_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nd,
    input  logic [COORD_W-1:0] bb_minX,
    input  logic [COORD_W-1:0] bb_maxX,
    input  logic [COORD_W-1:0] bb_minY,
    input  logic [COORD_W-1:0] bb_maxY,
    output logic               ds_rfd,
    input  logic               us_rfd,
    output logic               rdy,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frag_last,
    output logic               box_done
);

    localparam logic [COORD_W-1:0] LIM_X = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] LIM_Y = COORD_W'(SCREEN_H - 1);

    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    state_t             state, state_n;
    logic [COORD_W-1:0] min_x, min_x_n;
    logic [COORD_W-1:0] cmax_x, cmax_x_n;
    logic [COORD_W-1:0] cmax_y, cmax_y_n;
    logic               ds_rfd_n, rdy_n, frag_last_n, box_done_n;
    logic [COORD_W-1:0] pix_x_n, pix_y_n;
    logic [COORD_W-1:0] in_cmax_x, in_cmax_y;

    assign in_cmax_x = clamp(bb_maxX, LIM_X);
    assign in_cmax_y = clamp(bb_maxY, LIM_Y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            min_x     <= '0;
            cmax_x    <= '0;
            cmax_y    <= '0;
            ds_rfd    <= 1'b1;
            rdy       <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            frag_last <= 1'b0;
            box_done  <= 1'b0;
        end else begin
            state     <= state_n;
            min_x     <= min_x_n;
            cmax_x    <= cmax_x_n;
            cmax_y    <= cmax_y_n;
            ds_rfd    <= ds_rfd_n;
            rdy       <= rdy_n;
            pix_x     <= pix_x_n;
            pix_y     <= pix_y_n;
            frag_last <= frag_last_n;
            box_done  <= box_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        min_x_n     = min_x;
        cmax_x_n    = cmax_x;
        cmax_y_n    = cmax_y;
        ds_rfd_n    = ds_rfd;
        rdy_n       = rdy;
        pix_x_n     = pix_x;
        pix_y_n     = pix_y;
        frag_last_n = frag_last;
        box_done_n  = 1'b0;

        case (state)
            IDLE: begin
                ds_rfd_n = 1'b1;
                rdy_n    = 1'b0;
                if (nd) begin
                    min_x_n  = bb_minX;
                    cmax_x_n = in_cmax_x;
                    cmax_y_n = in_cmax_y;
                    if (bb_minX <= in_cmax_x && bb_minY <= in_cmax_y) begin
                        state_n     = SCAN;
                        ds_rfd_n    = 1'b0;
                        rdy_n       = 1'b1;
                        pix_x_n     = bb_minX;
                        pix_y_n     = bb_minY;
                        frag_last_n = (bb_minX == in_cmax_x) && (bb_minY == in_cmax_y);
                    end else begin
                        // Empty box: report completion without emitting anything.
                        box_done_n = 1'b1;
                    end
                end
            end
            SCAN: begin
                ds_rfd_n = 1'b0;
                if (rdy && us_rfd) begin
                    if (frag_last) begin
                        state_n     = IDLE;
                        rdy_n       = 1'b0;
                        ds_rfd_n    = 1'b1;
                        frag_last_n = 1'b0;
                        box_done_n  = 1'b1;
                    end else if (pix_x < cmax_x) begin
                        pix_x_n     = pix_x + 1'b1;
                        frag_last_n = (pix_x_n == cmax_x) && (pix_y == cmax_y);
                    end else begin
                        pix_x_n     = min_x;
                        pix_y_n     = pix_y + 1'b1;
                        frag_last_n = (min_x == cmax_x) && (pix_y_n == cmax_y);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
